// File: rtl/crc_data_append.sv
// rtl/crc_data_append.sv - transmit-side CRC-16 generator that forwards packet words and appends a trailer.
// Single registered output stage; one trailer beat {16'h0000, crc} follows every completed packet.
module crc_data_append #(
    parameter logic [15:0] CRC_POLY = 16'h1021,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iWrSop,
    input  logic        iWrEop,
    input  logic        iWrVld,
    input  logic [31:0] iWrData,
    output logic        oWrReady,
    output logic        oWrSop,
    output logic        oWrEop,
    output logic        oWrVld,
    output logic        oWrLast,
    output logic [31:0] oWrData,
    output logic        oAbort,
    input  logic        iReady
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        APPEND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic        vld_q, vld_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic        last_q, last_d;
    logic [31:0] data_q, data_d;
    logic        abort_q, abort_d;
    logic        wr_ready;
    logic        accept;
    logic        out_free;

    // MSB-first bit-serial CRC over one 32-bit word, unrolled into combinational logic.
    function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [31:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

    assign out_free = !vld_q || iReady;
    assign wr_ready = (state_q != APPEND) && out_free;
    assign accept   = iWrVld && wr_ready;

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        vld_d   = vld_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        last_d  = last_q;
        data_d  = data_q;
        abort_d = 1'b0;

        if (vld_q && iReady) begin
            vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Words arriving outside a packet are swallowed without touching the CRC.
                if (accept && iWrSop) begin
                    vld_d   = 1'b1;
                    sop_d   = 1'b1;
                    eop_d   = 1'b0;
                    last_d  = 1'b0;
                    data_d  = iWrData;
                    crc_d   = crc_step(CRC_INIT, iWrData);
                    state_d = iWrEop ? APPEND : DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    vld_d  = 1'b1;
                    sop_d  = iWrSop;
                    eop_d  = 1'b0;
                    last_d = 1'b0;
                    data_d = iWrData;
                    if (iWrSop) begin
                        abort_d = 1'b1;
                        crc_d   = crc_step(CRC_INIT, iWrData);
                    end else begin
                        crc_d   = crc_step(crc_q, iWrData);
                    end
                    if (iWrEop) begin
                        state_d = APPEND;
                    end
                end
            end
            APPEND: begin
                if (out_free) begin
                    vld_d   = 1'b1;
                    sop_d   = 1'b0;
                    eop_d   = 1'b1;
                    last_d  = 1'b1;
                    data_d  = {16'h0000, crc_q};
                    crc_d   = CRC_INIT;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                crc_d   = CRC_INIT;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            crc_q   <= CRC_INIT;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= 32'h0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            last_q  <= last_d;
            data_q  <= data_d;
            abort_q <= abort_d;
        end
    end

    assign oWrReady = wr_ready;
    assign oWrVld   = vld_q;
    assign oWrSop   = sop_q;
    assign oWrEop   = eop_q;
    assign oWrLast  = last_q;
    assign oWrData  = data_q;
    assign oAbort   = abort_q;

endmodule

// File: tb/tb_crc_data_append.sv
// tb/tb_crc_data_append.sv - self-checking bench for crc_data_append against a byte-table CRC model.
// Two instances share stimulus: one with CRC_INIT=0 for hand-computed constants, one with defaults.
module tb_crc_data_append;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_sop, wr_eop, wr_vld, rdy;
    logic [31:0] wr_data;

    logic        a_ready, a_sop, a_eop, a_vld, a_last, a_abort;
    logic [31:0] a_data;
    logic        b_ready, b_sop, b_eop, b_vld, b_last, b_abort;
    logic [31:0] b_data;

    always #5 clk = ~clk;

    crc_data_append #(.CRC_INIT(16'h0000)) dut_z (
        .iClk(clk), .iRst_n(rst_n), .iWrSop(wr_sop), .iWrEop(wr_eop), .iWrVld(wr_vld),
        .iWrData(wr_data), .oWrReady(a_ready), .oWrSop(a_sop), .oWrEop(a_eop), .oWrVld(a_vld),
        .oWrLast(a_last), .oWrData(a_data), .oAbort(a_abort), .iReady(rdy)
    );

    crc_data_append dut (
        .iClk(clk), .iRst_n(rst_n), .iWrSop(wr_sop), .iWrEop(wr_eop), .iWrVld(wr_vld),
        .iWrData(wr_data), .oWrReady(b_ready), .oWrSop(b_sop), .oWrEop(b_eop), .oWrVld(b_vld),
        .oWrLast(b_last), .oWrData(b_data), .oAbort(b_abort), .iReady(rdy)
    );

    typedef struct {
        logic [31:0] d;
        logic        s;
        logic        e;
        logic        l;
    } out_t;

    typedef struct {
        int          n;
        logic [31:0] w [4];
        logic [31:0] trl;
    } vec_t;

    out_t        q0[$];
    out_t        q1[$];
    logic [31:0] pkt[$];
    logic [31:0] run_a[$];
    logic [15:0] tbl [256];
    vec_t        vt [3];

    int ntests = 0;
    int nfail = 0;
    int cyc = 0;
    int mode = 0;
    int nlow = 0;
    int nabort_a = 0;
    int nabort_b = 0;
    int abort_idx = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference CRC: classic byte-at-a-time table lookup over the packet, from abort_idx onward.
    function automatic logic [15:0] crc_model(input logic [15:0] init);
        logic [15:0] c;
        logic [7:0]  by;
        int          from;
        c    = init;
        from = (abort_idx < 0) ? 0 : abort_idx;
        for (int i = from; i < pkt.size(); i++) begin
            for (int b = 3; b >= 0; b--) begin
                by = pkt[i][8*b +: 8];
                c  = {c[7:0], 8'h00} ^ tbl[c[15:8] ^ by];
            end
        end
        return c;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        case (mode)
            0:       rdy = 1'b1;
            1:       rdy = cyc[0];
            default: rdy = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            wr_vld = 1'b0;
            wr_sop = 1'b0;
            wr_eop = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic s, input logic e);
        int  g;
        bit  done;
        g    = 0;
        done = 0;
        while (!done && g < 300) begin
            tick();
            wr_vld  = 1'b1;
            wr_sop  = s;
            wr_eop  = e;
            wr_data = d;
            #1;
            if (a_ready) done = 1;
            g++;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_pkt();
        for (int i = 0; i < pkt.size(); i++)
            send_word(pkt[i], i == 0, i == pkt.size() - 1);
    endtask

    task automatic wait_out(input int n);
        int g;
        g = 0;
        while ((q0.size() < n || q1.size() < n) && g < 600) begin
            idle(1);
            g++;
        end
        if (g >= 600) chk("out_timeout", 64'd0, 64'd1);
        idle(3);
    endtask

    task automatic verify(input string tag, input bit which, input logic [31:0] exp_tr);
        out_t got[$];
        int   n;
        got = which ? q1 : q0;
        n   = pkt.size();
        chk({tag, "_count"}, 64'(got.size()), 64'(n + 1));
        if (got.size() == n + 1) begin
            for (int i = 0; i < n; i++) begin
                chk({tag, "_data"}, {29'd0, got[i].s, got[i].e, got[i].l, got[i].d},
                    {29'd0, (i == 0 || i == abort_idx), 1'b0, 1'b0, pkt[i]});
            end
            chk({tag, "_trailer"}, {29'd0, got[n].s, got[n].e, got[n].l, got[n].d},
                {29'd0, 1'b0, 1'b1, 1'b1, exp_tr});
        end
        if (which) q1.delete(); else q0.delete();
    endtask

    task automatic verify_both(input string tag);
        verify({tag, "_z"}, 1'b0, {16'h0, crc_model(16'h0000)});
        verify({tag, "_d"}, 1'b1, {16'h0, crc_model(16'hFFFF)});
    endtask

    // Output monitor: samples between edges so the values seen are those the next posedge acts on.
    logic        stall_a = 1'b0;
    logic [31:0] held_a = 32'h0;
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a) chk("stall_hold", {31'd0, a_vld, a_data}, {31'd0, 1'b1, held_a});
            stall_a = a_vld && !rdy;
            held_a  = a_data;
            if (a_vld && rdy) q0.push_back('{d: a_data, s: a_sop, e: a_eop, l: a_last});
            if (b_vld && rdy) q1.push_back('{d: b_data, s: b_sop, e: b_eop, l: b_last});
            if (a_abort) nabort_a++;
            if (b_abort) nabort_b++;
            if (!a_ready && rdy) nlow++;
        end
    end

    initial begin
        logic [15:0] c;
        for (int b = 0; b < 256; b++) begin
            c = 16'(b) << 8;
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            tbl[b] = c;
        end

        vt[0].n = 1; vt[0].w = '{32'h0000_0001, 32'h0, 32'h0, 32'h0}; vt[0].trl = 32'h0000_1021;
        vt[1].n = 3; vt[1].w = '{32'h0, 32'h0, 32'h0, 32'h0};          vt[1].trl = 32'h0000_0000;
        vt[2].n = 1; vt[2].w = '{32'h0000_0002, 32'h0, 32'h0, 32'h0}; vt[2].trl = 32'h0000_2042;

        rst_n = 1'b0; wr_sop = 0; wr_eop = 0; wr_vld = 0; wr_data = 0; rdy = 1;
        repeat (3) @(negedge clk);
        chk("rst_outs_z", {27'd0, a_sop, a_eop, a_vld, a_last, a_abort, a_data}, 64'd0);
        chk("rst_outs_d", {27'd0, b_sop, b_eop, b_vld, b_last, b_abort, b_data}, 64'd0);
        rst_n = 1'b1;
        idle(2);
        chk("rst_ready", {63'd0, a_ready}, 64'd1);

        mode = 0;
        for (int t = 0; t < 3; t++) begin
            pkt.delete();
            for (int i = 0; i < vt[t].n; i++) pkt.push_back(vt[t].w[i]);
            nlow = 0;
            send_pkt();
            wait_out(pkt.size() + 1);
            chk("ready_low_once", 64'(nlow), 64'd1);
            verify("vec_z", 1'b0, vt[t].trl);
            verify("vec_d", 1'b1, {16'h0, crc_model(16'hFFFF)});
        end

        // Same 4-word packet with iReady high, then toggling; both runs must match the model.
        pkt.delete();
        for (int i = 0; i < 4; i++) pkt.push_back($urandom);
        send_pkt();
        wait_out(5);
        verify_both("bp_ready");
        mode = 1;
        send_pkt();
        wait_out(5);
        verify_both("bp_toggle");

        mode = 0;
        nabort_a = 0; nabort_b = 0;
        pkt.delete();
        for (int i = 0; i < 4; i++) pkt.push_back($urandom);
        send_word(pkt[0], 1, 0);
        send_word(pkt[1], 0, 0);
        send_word(pkt[2], 1, 0);
        send_word(pkt[3], 0, 1);
        abort_idx = 2;
        wait_out(5);
        chk("abort_pulse_z", 64'(nabort_a), 64'd1);
        chk("abort_pulse_d", 64'(nabort_b), 64'd1);
        verify_both("abort");
        abort_idx = -1;

        send_word($urandom, 1, 0);
        send_word($urandom, 0, 0);
        tick();
        wr_vld = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_z", {27'd0, a_sop, a_eop, a_vld, a_last, a_abort, a_data}, 64'd0);
        chk("async_rst_d", {27'd0, b_sop, b_eop, b_vld, b_last, b_abort, b_data}, 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        q0.delete(); q1.delete();
        pkt.delete();
        for (int i = 0; i < 3; i++) pkt.push_back($urandom);
        send_pkt();
        wait_out(4);
        verify_both("post_rst");

        mode = 2;
        for (int p = 0; p < 30; p++) begin
            if ($urandom_range(0, 3) == 0) send_word($urandom, 0, 0);
            pkt.delete();
            for (int i = 0; i < $urandom_range(1, 64); i++) pkt.push_back($urandom);
            send_pkt();
            wait_out(pkt.size() + 1);
            verify_both("rand");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/crc_data_append.md
Name: crc_data_append

Overview:
- Transmit-side CRC generator for the switch's 32-bit packet stream, upstream of the read-side CRC checker.
- Takes an sop/eop/valid framed packet and forwards every data word unchanged.
- Computes a running CRC-16 over all accepted data words.
- After the eop data word, inserts one extra trailer word {16'h0000, crc16}, flagged Last and Eop. The receive-side checker verifies this trailer.

Parameters:
- CRC_POLY, 16'h1021, generator polynomial (normal form, MSB-first, no reflection).
- CRC_INIT, 16'hFFFF, CRC register value at start of every packet; no final XOR.

Ports:
- iClk  input  1  clock.
- iRst_n  input  1  asynchronous, active-low reset.
- iWrSop  input  1  first word of packet (qualified by iWrVld).
- iWrEop  input  1  last data word of packet (qualified by iWrVld).
- iWrVld  input  1  input word valid.
- iWrData  input  32  input data word.
- oWrReady  output  1  block can accept an input word this cycle.
- oWrSop  output  1  first word of output frame.
- oWrEop  output  1  final beat of output frame (the CRC trailer word only).
- oWrVld  output  1  output word valid.
- oWrLast  output  1  current output word is the CRC trailer.
- oWrData  output  32  output data / trailer word.
- oAbort  output  1  one-cycle pulse: sop arrived mid-packet, so the previous packet was dropped without a trailer.
- iReady  input  1  downstream accepts the output word this cycle.

Behaviour:
- Reset: all outputs 0, output register empty, CRC register = CRC_INIT, FSM = IDLE. A reset mid-packet discards the packet and emits no trailer.
- Handshakes:
  - Input transfer occurs when iWrVld && oWrReady.
  - Output transfer occurs when oWrVld && iReady.
  - oWrVld/oWrData must hold stable while oWrVld && !iReady.
- Single registered output stage, latency 1 cycle from input accept to oWrVld.
- oWrReady = (state != APPEND) && (!oWrVld || iReady). The value is combinational from state and register occupancy only; it does not depend on iWrVld.
- CRC step: processes all 32 bits MSB-first (bit31 first). For each bit: fb = crc[15] ^ d; crc = {crc[14:0],1'b0} ^ (fb ? CRC_POLY : 0). Implement as a combinational next-CRC function of (crc, data).
- FSM states:
  - IDLE: accept a word only if iWrSop; a word without sop is accepted and dropped, with no output and no CRC update.
    - sop && !eop -> DATA; CRC register = step(CRC_INIT, data).
    - sop && eop -> APPEND; CRC register = step(CRC_INIT, data).
  - DATA: each accepted word updates CRC = step(crc, data).
    - eop -> APPEND.
    - sop without eop -> oAbort=1 for one cycle; CRC restarts from CRC_INIT with this word; stay in DATA.
    - sop && eop -> oAbort=1; CRC restarts; go to APPEND.
  - APPEND: oWrReady=0. When the output register is empty or transferring this cycle, load {16'h0000, crc}, oWrLast=1, oWrEop=1, oWrSop=0. Then set CRC register = CRC_INIT and go to IDLE.
- Forwarded data words carry oWrSop as received, oWrEop=0, oWrLast=0.
- Throughput: one bubble per packet (the trailer cycle); otherwise one word per cycle when iReady stays high.
- Back-to-back packets: a sop presented in the cycle after the trailer is loaded is accepted normally.

Test Plan:
- CRC_INIT=0; packet of one word 32'h0000_0001 (sop&eop), iReady=1 -> output words: 32'h0000_0001 (sop=1, eop=0, last=0), then 32'h0000_1021 (eop=1, last=1).
- CRC_INIT=0; 3-word packet of zeros, then 1-word packet 32'h0000_0002 -> first trailer 32'h0000_0000; second trailer 32'h0000_2042; oWrReady low exactly one cycle per trailer.
- Backpressure: iReady toggled 1/0 every cycle during a 4-word packet -> oWrData/oWrVld stable while stalled; same words and trailer as the iReady=1 run; no word lost or duplicated.
- Abort: sop, 2 words, then a new sop before eop -> oAbort pulses once; no trailer for the first packet; the second packet's trailer equals a golden model started at CRC_INIT.
- Reset asserted in DATA after 2 words -> outputs 0 immediately (async); after release the next packet's trailer matches the golden model from CRC_INIT.
- Loopback: default parameters, random packets of 1–64 words fed into the receive-side checker -> checker error flag never asserts; corrupting one data bit -> error asserts on that packet.
